note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter: ADDR_W, 6, song-table address width; the table holds 2**ADDR_W entries.
REQ-002 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  single-cycle request to begin playback at address 0.
REQ-005 Port: stop  input  1  single-cycle request to abort playback.
REQ-006 Port: loop_en  input  1  restart at address 0 on reaching END; sampled in DECODE.
REQ-007 Port: unit_cycles  input  24  clock cycles per duration unit; sampled in DECODE; 0 is treated as 1.
REQ-008 Port: rom_addr  output  ADDR_W  song-table read address.
REQ-009 Port: rom_data  input  16  table word, valid one cycle after rom_addr changes; [15]=END, [14]=REST, [13:7]=note, [6:0]=length in units (0 is treated as 1).
REQ-010 Port: midi_data  output  8  note number to the tone generator, {1'b0, note}.
REQ-011 Port: midi_valid  output  1  one-cycle strobe that loads midi_data into the tone generator.
REQ-012 Port: note_on  output  1  high while a non-REST entry plays; the top level mutes audio when low.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: song_done  output  1  one-cycle pulse when playback ends naturally.

Function
REQ-015 States: IDLE, FETCH, DECODE, PLAY; all outputs registered.
REQ-016 IDLE: start -> FETCH with rom_addr=0; start while busy is ignored.
REQ-017 FETCH: lasts exactly 1 cycle with rom_addr stable, then -> DECODE.
REQ-018 DECODE, END set, loop_en=1, rom_addr!=0: rom_addr<=0, -> FETCH.
REQ-019 DECODE, END set, loop_en=0 or rom_addr==0: song_done pulse, note_on<=0, -> IDLE; this prevents livelock on an empty song.
REQ-020 DECODE, END clear, REST clear: midi_data<={1'b0,note}, midi_valid<=1, note_on<=1, -> PLAY.
REQ-021 DECODE, END clear, REST set: midi_valid stays 0, note_on<=0, midi_data holds its value, -> PLAY.
REQ-022 DECODE loads the remaining-units counter (7 bits) with max(length,1) and the cycle counter (24 bits) with max(unit_cycles,1).
REQ-023 PLAY lasts exactly max(length,1)*max(unit_cycles,1) cycles; entry period = that value + 2 cycles.
REQ-024 midi_valid is high only in the first PLAY cycle of a non-REST entry.
REQ-025 PLAY exit: rom_addr<=rom_addr+1 and -> FETCH; when rom_addr==2**ADDR_W-1, treat the exit as END per REQ-018/019 with no fetch.
REQ-026 note_on holds through FETCH/DECODE between consecutive notes and changes only in DECODE or on exit to IDLE.
REQ-027 stop in any non-IDLE state -> IDLE next cycle: note_on<=0, midi_valid<=0, no song_done, rom_addr<=0.
REQ-028 start and stop in the same cycle: stop wins, and the block ends in IDLE.
REQ-029 start in the same cycle that a natural end fires song_done: the block enters IDLE, and the start is ignored.
REQ-030 unit_cycles or loop_en changes during PLAY take effect only at the next DECODE.

Reset
REQ-031 rst_n low immediately forces IDLE, regardless of clk: rom_addr=0, midi_data=0, midi_valid=0, note_on=0, busy=0, song_done=0, all counters=0.
REQ-032 Reset deasserted mid-song leaves the block idle until a fresh start.

Verification
REQ-033 Table {C4 note 60 len 2, END}, unit_cycles=10, loop_en=0, start -> midi_valid with midi_data=60 once, note_on high for 20 PLAY cycles plus gaps, song_done exactly once, busy=0 afterwards.
REQ-034 Table {60 len1, REST len1, 62 len1, END}, unit_cycles=5 -> midi_valid twice (60, 62), note_on low for the 5-cycle rest, strobe spacing 7 and 14 cycles.
REQ-035 loop_en=1, table {64 len1, END}, unit_cycles=3 -> note 64 re-strobed every 3+2+2 cycles, song_done never pulses; stop -> IDLE within 1 cycle, note_on=0.
REQ-036 Table {END} with loop_en=1 -> song_done after 3 cycles, busy low, no midi_valid.
REQ-037 Length 0 and unit_cycles=0 -> PLAY lasts 1 cycle; full table of 64 non-END entries -> song_done after address 63 with no wrap fetch.
REQ-038 rst_n asserted mid-PLAY, asynchronous to clk -> all outputs 0 immediately; start+stop in the same cycle while idle -> remains IDLE.

Source files
------------

// File: rtl/note_sequencer.sv
// Song-table note sequencer. Walks a 16-bit song table, strobes note numbers
// to a tone generator, holds each entry for length * unit_cycles clocks and
// optionally loops back to address 0 when it reaches an END entry.
//
// Handshake: start/stop are single-cycle requests with no acknowledge. start is
// taken only in IDLE and only when stop is low. stop aborts from any busy state.
// rom_data must reflect rom_addr one cycle after rom_addr changes; the FETCH
// state provides exactly that one cycle of read latency.
module note_sequencer #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [23:0]       unit_cycles,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        midi_data,
  output logic              midi_valid,
  output logic              note_on,
  output logic              busy,
  output logic              song_done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_PLAY   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q,      state_d;
  logic [ADDR_W-1:0] rom_addr_q,   rom_addr_d;
  logic [7:0]        midi_data_q,  midi_data_d;
  logic              midi_valid_q, midi_valid_d;
  logic              note_on_q,    note_on_d;
  logic              song_done_q,  song_done_d;
  logic [6:0]        units_q,      units_d;
  logic [23:0]       cyc_q,        cyc_d;
  logic [23:0]       unit_len_q,   unit_len_d;
  logic              loop_q,       loop_d;

  logic              ent_end;
  logic              ent_rest;
  logic [6:0]        ent_note;
  logic [6:0]        ent_len;
  logic [23:0]       uc_eff;

  assign ent_end  = rom_data[15];
  assign ent_rest = rom_data[14];
  assign ent_note = rom_data[13:7];
  assign ent_len  = rom_data[6:0];
  assign uc_eff   = (unit_cycles == 24'd0) ? 24'd1 : unit_cycles;

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    midi_data_d  = midi_data_q;
    midi_valid_d = 1'b0;
    note_on_d    = note_on_q;
    song_done_d  = 1'b0;
    units_d      = units_q;
    cyc_d        = cyc_q;
    unit_len_d   = unit_len_q;
    loop_d       = loop_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d    = S_FETCH;
          rom_addr_d = '0;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        loop_d     = loop_en;
        unit_len_d = uc_eff;
        if (ent_end) begin
          // Looping from address 0 onto an END would spin forever, so an
          // empty song always finishes.
          if (loop_en && (rom_addr_q != '0)) begin
            rom_addr_d = '0;
            state_d    = S_FETCH;
          end else begin
            song_done_d = 1'b1;
            note_on_d   = 1'b0;
            rom_addr_d  = '0;
            state_d     = S_IDLE;
          end
        end else begin
          units_d = (ent_len == 7'd0) ? 7'd1 : ent_len;
          cyc_d   = uc_eff;
          state_d = S_PLAY;
          if (ent_rest) begin
            note_on_d = 1'b0;
          end else begin
            midi_data_d  = {1'b0, ent_note};
            midi_valid_d = 1'b1;
            note_on_d    = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (cyc_q > 24'd1) begin
          cyc_d = cyc_q - 24'd1;
        end else if (units_q > 7'd1) begin
          units_d = units_q - 7'd1;
          cyc_d   = unit_len_q;
        end else if (rom_addr_q == ADDR_MAX) begin
          // Last table slot finished: behave as if the next entry were END.
          if (loop_q) begin
            rom_addr_d = '0;
            state_d    = S_FETCH;
          end else begin
            song_done_d = 1'b1;
            note_on_d   = 1'b0;
            rom_addr_d  = '0;
            state_d     = S_IDLE;
          end
        end else begin
          rom_addr_d = rom_addr_q + 1'b1;
          state_d    = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a natural end in the same cycle.
    if (stop && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      note_on_d    = 1'b0;
      midi_valid_d = 1'b0;
      song_done_d  = 1'b0;
      rom_addr_d   = '0;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      midi_data_q  <= 8'd0;
      midi_valid_q <= 1'b0;
      note_on_q    <= 1'b0;
      song_done_q  <= 1'b0;
      units_q      <= 7'd0;
      cyc_q        <= 24'd0;
      unit_len_q   <= 24'd0;
      loop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      midi_data_q  <= midi_data_d;
      midi_valid_q <= midi_valid_d;
      note_on_q    <= note_on_d;
      song_done_q  <= song_done_d;
      units_q      <= units_d;
      cyc_q        <= cyc_d;
      unit_len_q   <= unit_len_d;
      loop_q       <= loop_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign midi_data  = midi_data_q;
  assign midi_valid = midi_valid_q;
  assign note_on    = note_on_q;
  assign song_done  = song_done_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: synchronous song-table model, expected
// note queue popped on every midi_valid strobe, timing checks in cycles.
module tb_note_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [23:0] unit_cycles;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  midi_data;
  logic        midi_valid;
  logic        note_on;
  logic        busy;
  logic        song_done;
  logic [1:0]  dbg_state;

  logic [15:0] rom_mem [64];
  logic [7:0]  exp_q [$];
  int          strobe_t [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_t = 0;
  int          on_cnt = 0;
  int          s = 0;

  localparam logic [15:0] END_W = 16'h8000;

  note_sequencer #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .unit_cycles(unit_cycles), .rom_addr(rom_addr), .rom_data(rom_data),
    .midi_data(midi_data), .midi_valid(midi_valid), .note_on(note_on),
    .busy(busy), .song_done(song_done), .dbg_state(dbg_state)
  );

  // Clock and song-table model (one cycle read latency).
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] note_w(input logic rest, input logic [6:0] note,
                                         input logic [6:0] len);
    return {1'b0, rest, note, len};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom_mem[i] = END_W;
  endtask

  task automatic clear_stats();
    strobe_t.delete();
    done_cnt = 0;
    on_cnt   = 0;
    done_t   = 0;
  endtask

  task automatic pulse_start();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) tick();
    check(tag, done_cnt > 0, 1);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (midi_valid) begin
        int n;
        n = exp_q.size();
        strobe_t.push_back(cyc);
        check("strobe_expected", n > 0, 1);
        if (n > 0) check("midi_data", midi_data, exp_q.pop_front());
      end
      if (song_done) begin
        done_cnt++;
        done_t = cyc;
      end
      if (note_on) on_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; unit_cycles = 24'd0;
    clear_rom();
    #12;
    check("rst_rom_addr", rom_addr, 0);
    check("rst_midi_data", midi_data, 0);
    check("rst_midi_valid", midi_valid, 0);
    check("rst_note_on", note_on, 0);
    check("rst_busy", busy, 0);
    check("rst_song_done", song_done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single note of 2 units x 10 cycles.
    clear_rom();
    rom_mem[0] = note_w(1'b0, 7'd60, 7'd2);
    unit_cycles = 24'd10; loop_en = 1'b0;
    clear_stats();
    exp_q.push_back(8'd60);
    pulse_start();
    check("t1_busy", busy, 1);
    wait_done("t1_done_seen", 200);
    repeat (3) tick();
    check("t1_strobes", strobe_t.size(), 1);
    check("t1_strobe_lat", strobe_t[0] - s, 4);
    check("t1_done_time", done_t - s, 26);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_note_on_cycles", on_cnt, 22);
    check("t1_busy_after", busy, 0);
    check("t1_note_on_after", note_on, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Note, rest, note.
    clear_rom();
    rom_mem[0] = note_w(1'b0, 7'd60, 7'd1);
    rom_mem[1] = note_w(1'b1, 7'd5, 7'd1);
    rom_mem[2] = note_w(1'b0, 7'd62, 7'd1);
    unit_cycles = 24'd5;
    clear_stats();
    exp_q.push_back(8'd60);
    exp_q.push_back(8'd62);
    pulse_start();
    wait_done("t2_done_seen", 200);
    repeat (3) tick();
    check("t2_strobes", strobe_t.size(), 2);
    check("t2_spacing", strobe_t[1] - strobe_t[0], 14);
    check("t2_note_on_cycles", on_cnt, 14);
    check("t2_done_time", done_t - s, 25);
    check("t2_midi_hold", midi_data, 62);
    check("t2_queue_empty", exp_q.size(), 0);

    // Looping single note, then abort.
    clear_rom();
    rom_mem[0] = note_w(1'b0, 7'd64, 7'd1);
    unit_cycles = 24'd3; loop_en = 1'b1;
    clear_stats();
    repeat (4) exp_q.push_back(8'd64);
    pulse_start();
    for (int i = 0; i < 200 && strobe_t.size() < 4; i++) tick();
    check("t3_strobes", strobe_t.size(), 4);
    for (int i = 1; i < 4; i++) check("t3_period", strobe_t[i] - strobe_t[i-1], 7);
    check("t3_note_on_playing", note_on, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t3_stop_busy", busy, 0);
    check("t3_stop_note_on", note_on, 0);
    check("t3_stop_addr", rom_addr, 0);
    repeat (10) tick();
    check("t3_no_done", done_cnt, 0);
    check("t3_no_more_strobes", strobe_t.size(), 4);

    // Empty song with loop enabled; a start during the end cycle is dropped.
    clear_rom();
    clear_stats();
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_done_pulse", song_done, 1);
    tick();
    check("t4_done_time", done_t - s, 4);
    check("t4_busy_after", busy, 0);
    check("t4_start_ignored", busy, 0);
    repeat (5) tick();
    check("t4_done_cnt", done_cnt, 1);
    check("t4_no_strobe", strobe_t.size(), 0);

    // Full table, zero length and zero unit_cycles.
    for (int i = 0; i < 64; i++) begin
      rom_mem[i] = note_w(1'b0, 7'(i), 7'd0);
      exp_q.push_back(8'(i));
    end
    unit_cycles = 24'd0; loop_en = 1'b0;
    clear_stats();
    pulse_start();
    wait_done("t5_done_seen", 500);
    repeat (3) tick();
    check("t5_strobes", strobe_t.size(), 64);
    check("t5_spacing", strobe_t[1] - strobe_t[0], 3);
    check("t5_done_time", done_t - s, 194);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_busy_after", busy, 0);
    check("t5_queue_empty", exp_q.size(), 0);

    // Asynchronous reset mid-PLAY.
    clear_rom();
    rom_mem[0] = note_w(1'b0, 7'd60, 7'd2);
    unit_cycles = 24'd10;
    clear_stats();
    exp_q.push_back(8'd60);
    pulse_start();
    for (int i = 0; i < 20 && strobe_t.size() < 1; i++) tick();
    check("t6_strobe_seen", strobe_t.size(), 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_note_on", note_on, 0);
    check("t6_rst_midi_data", midi_data, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rom_addr", rom_addr, 0);
    check("t6_rst_midi_valid", midi_valid, 0);
    check("t6_rst_song_done", song_done, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t6_idle_after_rst", busy, 0);

    // start and stop together while idle.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t7_busy", busy, 0);
    repeat (5) tick();
    check("t7_still_idle", busy, 0);
    check("t7_no_strobe", strobe_t.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
